// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the rotating one-hot counter monitor.
package ring_mon_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Widest counter rot() supports; callers zero-extend and slice back down.
  localparam int RM_MAX_W = 32;

  // Rotate the low w bits of c by one position in the given direction.
  function automatic logic [RM_MAX_W-1:0] rot(input logic [RM_MAX_W-1:0] c,
                                              input int unsigned       w,
                                              input logic              dir);
    logic [RM_MAX_W-1:0] mask;
    mask = ~({RM_MAX_W{1'b1}} << w);
    rot  = '0;
    case (dir)
      DIR_LEFT:  rot = ((c << 1) | (c >> (w - 1))) & mask;
      DIR_RIGHT: rot = ((c >> 1) | (c << (w - 1))) & mask;
      default:   rot = '0;
    endcase
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot validity check and binary index encoder.
module onehot_enc #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic             onehot,
  output logic [IDX_W-1:0] idx
);

  assign onehot = (data != '0) && ((data & (data - 1'b1)) == '0);

  // NOTE: idx gets a default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/ring_monitor.sv
// Passive checker for a rotating one-hot counter bus.
// Define RING_MON_CAPT_EN to capture expected/observed values on each violation.
module ring_monitor
  import ring_mon_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     valid,
  input  logic                     load,
  input  logic                     mod,
  input  logic [WIDTH-1:0]         data,
  output logic                     locked,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     err,
  output logic [ERR_W-1:0]         err_count,
  output logic [WIDTH-1:0]         err_exp,
  output logic [WIDTH-1:0]         err_obs
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [IDX_W-1:0]   pos_q, pos_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_count_q;

  logic               data_onehot;
  logic [IDX_W-1:0]   data_idx;
  logic [RM_MAX_W-1:0] exp_full;
  logic [WIDTH-1:0]   exp_val;

  onehot_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
    .data   (data),
    .onehot (data_onehot),
    .idx    (data_idx)
  );

  assign exp_full = rot(RM_MAX_W'(ref_q), WIDTH, mod);
  assign exp_val  = exp_full[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    pos_d   = pos_q;
    err_d   = 1'b0;
    if (valid) begin
      case (state_q)
        UNLOCKED: begin
          if (data_onehot) begin
            ref_d   = data;
            pos_d   = data_idx;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (load) begin
            if (data_onehot) begin
              ref_d = data;
              pos_d = data_idx;
            end else begin
              err_d   = 1'b1;
              state_d = UNLOCKED;
            end
          end else if (data == exp_val) begin
            ref_d = data;
            pos_d = data_idx;
          end else if (data_onehot) begin
            // Resync onto the observed value so one glitch is reported once.
            err_d = 1'b1;
            ref_d = data;
            pos_d = data_idx;
          end else begin
            err_d   = 1'b1;
            state_d = UNLOCKED;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      ref_q       <= '0;
      pos_q       <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      if (err_d && !(&err_count_q)) err_count_q <= err_count_q + 1'b1;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign pos       = pos_q;
  assign err       = err_q;
  assign err_count = err_count_q;

`ifdef RING_MON_CAPT_EN
  logic [WIDTH-1:0] cap_exp;
  logic [WIDTH-1:0] err_exp_q, err_obs_q;

  // A load violation has no rotation to predict, so the held reference stands in.
  assign cap_exp = load ? ref_q : exp_val;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_exp_q <= '0;
      err_obs_q <= '0;
    end else if (err_d) begin
      err_exp_q <= cap_exp;
      err_obs_q <= data;
    end
  end

  assign err_exp = err_exp_q;
  assign err_obs = err_obs_q;
`else
  assign err_exp = '0;
  assign err_obs = '0;
`endif

endmodule
